// File: rtl/proj_pkg.sv
// Shared types and constants for the FM projection index sequencer.
// Provides buffer size, index type and counter FSM states.
package proj_pkg;

    localparam int FM_BUFFER_SIZE = 16;

    typedef logic [FM_BUFFER_SIZE-1:0] fm_index_t;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        COUNT,
        DONE
    } counter_state_e;

endpackage

// File: rtl/proj_counter.sv
// Single-pass index sequencer for the frequency-moment buffer.
// Ports: clk, rst_n (sync, active-high), start (pulse),
//        index (current buffer index), finished_count (pass done).
module proj_counter
    import proj_pkg::*;
#(
    parameter int FM_BUFFER_SIZE = proj_pkg::FM_BUFFER_SIZE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic [FM_BUFFER_SIZE-1:0] index,
    output logic                      finished_count
);

    localparam logic [FM_BUFFER_SIZE-1:0] IDX_ZERO = '0;
    localparam logic [FM_BUFFER_SIZE-1:0] IDX_ONE  =
        FM_BUFFER_SIZE'(1);
    localparam logic [FM_BUFFER_SIZE-1:0] IDX_PRE  =
        FM_BUFFER_SIZE'(FM_BUFFER_SIZE - 2);
    localparam logic [FM_BUFFER_SIZE-1:0] IDX_LAST =
        FM_BUFFER_SIZE'(FM_BUFFER_SIZE - 1);

    counter_state_e state;

    // rst_n is active-high; start beats every non-reset transition,
    // including the terminal edge, so a restart never flags done.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state          <= IDLE;
            index          <= IDX_ZERO;
            finished_count <= 1'b0;
        end else if (start) begin
            state          <= ARM;
            index          <= IDX_ZERO;
            finished_count <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    index          <= IDX_ZERO;
                    finished_count <= 1'b0;
                end
                ARM, COUNT: begin
                    // ARM also checks the terminal value so a
                    // two-entry buffer finishes straight from ARM.
                    if (index == IDX_PRE) begin
                        state          <= DONE;
                        index          <= IDX_LAST;
                        finished_count <= 1'b1;
                    end else begin
                        state <= COUNT;
                        index <= (state == ARM) ? IDX_ONE
                                                : index + IDX_ONE;
                    end
                end
                DONE: begin
                    index          <= IDX_LAST;
                    finished_count <= 1'b1;
                end
                default: begin
                    state          <= IDLE;
                    index          <= IDX_ZERO;
                    finished_count <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proj_counter.sv
// Directed scoreboard bench for proj_counter.
// Expected index/finished pairs are queued per step and popped after the edge.
module tb_proj_counter;

    localparam int N = 16;

    typedef struct {
        int   idx;
        logic fin;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  index;
    logic          finished_count;

    int errors = 0;
    int checks = 0;

    exp_t sb[$];

    int   m_idx    = 0;
    logic m_active = 1'b0;
    logic m_fin    = 1'b0;

    proj_counter #(.FM_BUFFER_SIZE(N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .index          (index),
        .finished_count (finished_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d required %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, push model expectation, compare after edge.
    task automatic step(input logic s, input logic r, input string tag);
        exp_t e;
        exp_t got;
        @(negedge clk);
        start = s;
        rst_n = r;
        if (r) begin
            m_idx = 0; m_active = 1'b0; m_fin = 1'b0;
        end else if (s) begin
            m_idx = 0; m_active = 1'b1; m_fin = 1'b0;
        end else if (m_active && m_idx < N - 1) begin
            m_idx++;
            m_fin = (m_idx == N - 1);
        end
        e.idx = m_idx;
        e.fin = m_fin;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty got 0 required 1", tag);
        end else begin
            got = sb.pop_front();
            chk({tag, "_index"}, int'(index), got.idx);
            chk({tag, "_fin"}, int'(finished_count), int'(got.fin));
        end
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, tag);
    endtask

    initial begin
        start = 1'b0;
        rst_n = 1'b1;

        step(1'b0, 1'b1, "reset");
        run(2, "idle");

        step(1'b1, 1'b0, "p1_start");
        run(N - 1, "p1");
        chk("p1_last_index", int'(index), N - 1);
        chk("p1_last_fin", int'(finished_count), 1);
        run(5, "p1_hold");
        chk("hold_index", int'(index), N - 1);

        step(1'b1, 1'b0, "p2_start");
        run(7, "p2");
        chk("p2_at7", int'(index), 7);
        step(1'b0, 1'b1, "midreset");
        chk("midreset_index", int'(index), 0);
        run(4, "after_reset");

        step(1'b1, 1'b0, "p3_start");
        run(N - 1, "p3");
        chk("p3_fin", int'(finished_count), 1);

        step(1'b1, 1'b0, "p4_start");
        run(9, "p4");
        step(1'b1, 1'b0, "restart9");
        chk("restart9_index", int'(index), 0);
        run(N - 1, "p4b");

        step(1'b1, 1'b0, "done_restart");
        run(N - 1, "p5");

        step(1'b1, 1'b0, "held1");
        step(1'b1, 1'b0, "held2");
        step(1'b1, 1'b0, "held3");
        run(N - 1, "p6");

        step(1'b1, 1'b0, "p7_start");
        run(N - 2, "p7");
        step(1'b1, 1'b0, "terminal_restart");
        chk("terminal_fin", int'(finished_count), 0);
        run(N - 1, "p7b");

        step(1'b1, 1'b1, "reset_beats_start");
        run(3, "idle2");

        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running required finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/proj_counter.md
Name: proj_counter

Overview:
- Single-pass index sequencer for the frequency-moment (FM) buffer.
- On a one-cycle `start` pulse it issues buffer indices 0, 1, …, FM_BUFFER_SIZE-1 on `index`, one per clock.
- It raises `finished_count` when the last index is reached, then holds.
- Downstream projection logic uses `index` to address the buffer and `finished_count` to end the pass.

Parameters:
- FM_BUFFER_SIZE, default proj_pkg::FM_BUFFER_SIZE (16): number of buffer entries. It also sets the bit width of `index`. Legal range ≥ 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset.
  - Synchronous, active-high: sampled 1 at a rising edge resets the block.
  - The port keeps the codebase name rst_n, but its polarity is active-high.
- start  in  1  single-cycle pulse that begins, or restarts, a counting pass.
- index  out  FM_BUFFER_SIZE  current buffer index, zero-extended.
- finished_count  out  1  high while `index` equals FM_BUFFER_SIZE-1 after a pass.

Behaviour:
- State machine states: IDLE, ARM, COUNT, DONE. State, `index` and `finished_count` are all registered.
- Reset (rst_n=1 at a rising edge):
  - state ← IDLE; index ← 0; finished_count ← 0.
  - Reset has priority over start.
- IDLE: index holds 0. `start`=1 at an edge → ARM.
- ARM:
  - index = 0 for exactly one cycle after the start edge; this is the first issued index.
  - Next edge → COUNT, index ← 1.
- COUNT: index increments by 1 per edge.
  - When index is FM_BUFFER_SIZE-2 at an edge: index ← FM_BUFFER_SIZE-1, state ← DONE, finished_count ← 1.
- Latency: index = k, for k in 0..FM_BUFFER_SIZE-1, is valid k+1 cycles after the edge that sampled `start`. finished_count rises together with the final index.
- DONE:
  - index holds FM_BUFFER_SIZE-1 and finished_count stays 1 (no wrap-around).
  - Held until `start` or reset.
- `start` in any non-reset state (ARM, COUNT, DONE):
  - index ← 0, finished_count ← 0, state ← ARM. The pass restarts from the beginning.
  - A start arriving on the terminal edge also wins: restart, no finished pulse.
- `start` held high for several cycles: each sampled cycle re-arms, so index stays 0. Counting begins after start deasserts.
- Reset mid-pass: the next edge forces index to 0, finished_count to 0 and state to IDLE. A new start is required afterwards.
- Arithmetic: index is an unsigned FM_BUFFER_SIZE-bit register. Its maximum value, FM_BUFFER_SIZE-1, always fits, so no overflow is possible.
- No X on outputs after the first reset edge.

Decomposition:
- proj_pkg holds:
  - FM_BUFFER_SIZE constant;
  - typedef fm_index_t = logic [FM_BUFFER_SIZE-1:0];
  - enum counter_state_e {IDLE, ARM, COUNT, DONE}.
- No sub-modules: a single-module FSM plus counter register.

Test Plan (FM_BUFFER_SIZE=16):
- Reset: rst_n=1 for one edge, then 0 → index=0, finished_count=0, state IDLE.
- Normal pass: one-cycle start pulse.
  - 1 cycle later: index=0.
  - Then 1, 2, …, 15 on successive edges.
  - finished_count=0 until index=15, then 1.
- Hold: 5 idle cycles after the pass → index stays 15, finished_count stays 1 (no wrap).
- Reset mid-pass: assert rst_n at index=7 → next edge index=0, finished_count=0. Release; no further counting without start.
- Second pass after the reset: one-cycle start pulse → index again 0, then 1..15, finished_count=1 at 15. Confirms re-use.
- Restart mid-pass: start pulse at index=9 → next cycle index=0, finished_count=0, then a full 1..15 sequence. A start while in DONE behaves identically.
